// File: rtl/task_sequencer_axil_if.sv
// AXI4-Lite bundle between the task sequencer (master) and the test peripheral (slave).
// One transaction outstanding at a time; the slave may stall any channel indefinitely.
interface task_sequencer_axil_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic              awready;
  logic [DATA_W-1:0] wdata;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport master (
    output awaddr, awvalid, input awready,
    output wdata, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awvalid, output awready,
    input wdata, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/task_sequencer_axil.sv
// AXI4-Lite master: reads the task-enable mask, then per enabled task writes CMD and polls STATUS.
// All bus outputs are registered and held until handshake; any channel may stall without limit.
module task_sequencer_axil #(
  parameter int                          M_AXI_ADDR_WIDTH = 32,
  parameter int                          M_AXI_DATA_WIDTH = 32,
  parameter int                          NUM_TASKS        = 32,
  parameter logic [M_AXI_ADDR_WIDTH-1:0] BASE_ADDR        = 32'h4000_0000,
  parameter int                          POLL_LIMIT       = 1024
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  task_sequencer_axil_if.master m_axi,
  input  logic                  start_tests,
  output logic [NUM_TASKS-1:0]  enabled_tasks,
  output logic [31:0]           current_task_number,
  output logic                  busy,
  output logic [NUM_TASKS-1:0]  task_fail,
  output logic                  bus_error,
  output logic                  tasks_done
);
  localparam int AW    = M_AXI_ADDR_WIDTH;
  localparam int DW    = M_AXI_DATA_WIDTH;
  localparam int IDX_W = (NUM_TASKS > 1) ? $clog2(NUM_TASKS) : 1;
  localparam int PTR_W = $clog2(NUM_TASKS + 1);
  localparam int PC_W  = $clog2(POLL_LIMIT + 1);

  localparam logic [AW-1:0] ADDR_EN  = BASE_ADDR;
  localparam logic [AW-1:0] ADDR_CMD = BASE_ADDR + AW'(4);
  localparam logic [AW-1:0] ADDR_ST  = BASE_ADDR + AW'(8);

  typedef enum logic [3:0] {
    S_IDLE, S_EN_AR, S_EN_R, S_SCAN, S_CMD_W, S_CMD_B, S_ST_AR, S_ST_R, S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [AW-1:0]        araddr_q, araddr_d;
  logic                 arvalid_q, arvalid_d;
  logic                 rready_q, rready_d;
  logic [AW-1:0]        awaddr_q, awaddr_d;
  logic                 awvalid_q, awvalid_d;
  logic [DW-1:0]        wdata_q, wdata_d;
  logic                 wvalid_q, wvalid_d;
  logic                 bready_q, bready_d;
  logic [NUM_TASKS-1:0] enabled_q, enabled_d;
  logic [NUM_TASKS-1:0] task_fail_q, task_fail_d;
  logic [31:0]          cur_q, cur_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [PC_W-1:0]      poll_cnt_q, poll_cnt_d;
  logic                 busy_q, busy_d;
  logic                 bus_error_q, bus_error_d;
  logic                 done_q, done_d;

  logic                 ar_hs, r_hs, b_hs;
  logic [PC_W-1:0]      poll_inc;
  logic                 scan_hit;
  logic [IDX_W-1:0]     scan_idx;

  // Lowest enabled index at or above ptr; ptr == NUM_TASKS matches nothing.
  always_comb begin
    scan_hit = 1'b0;
    scan_idx = '0;
    for (int i = NUM_TASKS - 1; i >= 0; i--) begin
      if (enabled_q[i] && (i >= int'(ptr_q))) begin
        scan_hit = 1'b1;
        scan_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    araddr_d    = araddr_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    awaddr_d    = awaddr_q;
    awvalid_d   = awvalid_q;
    wdata_d     = wdata_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    enabled_d   = enabled_q;
    task_fail_d = task_fail_q;
    cur_d       = cur_q;
    idx_d       = idx_q;
    ptr_d       = ptr_q;
    poll_cnt_d  = poll_cnt_q;
    bus_error_d = bus_error_q;
    // The pulse trails the DONE state by one cycle.
    done_d      = (state_q == S_DONE);

    ar_hs    = arvalid_q & m_axi.arready;
    r_hs     = rready_q & m_axi.rvalid;
    b_hs     = bready_q & m_axi.bvalid;
    poll_inc = poll_cnt_q + PC_W'(1);

    case (state_q)
      S_IDLE: begin
        if (start_tests) begin
          task_fail_d = '0;
          bus_error_d = 1'b0;
          ptr_d       = '0;
          araddr_d    = ADDR_EN;
          arvalid_d   = 1'b1;
          state_d     = S_EN_AR;
        end
      end
      S_EN_AR: begin
        if (ar_hs) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_EN_R;
        end
      end
      S_EN_R: begin
        if (r_hs) begin
          rready_d = 1'b0;
          if (m_axi.rresp != 2'b00) begin
            bus_error_d = 1'b1;
            state_d     = S_DONE;
          end else begin
            enabled_d = m_axi.rdata[NUM_TASKS-1:0];
            state_d   = S_SCAN;
          end
        end
      end
      S_SCAN: begin
        if (scan_hit) begin
          idx_d     = scan_idx;
          cur_d     = 32'(scan_idx);
          awaddr_d  = ADDR_CMD;
          wdata_d   = DW'(scan_idx);
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          state_d   = S_CMD_W;
        end else begin
          state_d = S_DONE;
        end
      end
      S_CMD_W: begin
        // AW and W retire independently; move on once neither is pending.
        awvalid_d = awvalid_q & ~m_axi.awready;
        wvalid_d  = wvalid_q & ~m_axi.wready;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = S_CMD_B;
        end
      end
      S_CMD_B: begin
        if (b_hs) begin
          bready_d = 1'b0;
          if (m_axi.bresp != 2'b00) begin
            bus_error_d = 1'b1;
            state_d     = S_DONE;
          end else begin
            poll_cnt_d = '0;
            araddr_d   = ADDR_ST;
            arvalid_d  = 1'b1;
            state_d    = S_ST_AR;
          end
        end
      end
      S_ST_AR: begin
        if (ar_hs) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_ST_R;
        end
      end
      S_ST_R: begin
        if (r_hs) begin
          rready_d = 1'b0;
          if (m_axi.rresp != 2'b00) begin
            bus_error_d = 1'b1;
            state_d     = S_DONE;
          end else begin
            poll_cnt_d = poll_inc;
            if (m_axi.rdata[0]) begin
              task_fail_d[idx_q] = m_axi.rdata[1];
              ptr_d              = PTR_W'(idx_q) + PTR_W'(1);
              state_d            = S_SCAN;
            end else if (poll_inc == PC_W'(POLL_LIMIT)) begin
              task_fail_d[idx_q] = 1'b1;
              ptr_d              = PTR_W'(idx_q) + PTR_W'(1);
              state_d            = S_SCAN;
            end else begin
              araddr_d  = ADDR_ST;
              arvalid_d = 1'b1;
              state_d   = S_ST_AR;
            end
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      araddr_q    <= '0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      awaddr_q    <= '0;
      awvalid_q   <= 1'b0;
      wdata_q     <= '0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      enabled_q   <= '0;
      task_fail_q <= '0;
      cur_q       <= '0;
      idx_q       <= '0;
      ptr_q       <= '0;
      poll_cnt_q  <= '0;
      busy_q      <= 1'b0;
      bus_error_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      araddr_q    <= araddr_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      awaddr_q    <= awaddr_d;
      awvalid_q   <= awvalid_d;
      wdata_q     <= wdata_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      enabled_q   <= enabled_d;
      task_fail_q <= task_fail_d;
      cur_q       <= cur_d;
      idx_q       <= idx_d;
      ptr_q       <= ptr_d;
      poll_cnt_q  <= poll_cnt_d;
      busy_q      <= busy_d;
      bus_error_q <= bus_error_d;
      done_q      <= done_d;
    end
  end

  assign m_axi.araddr        = araddr_q;
  assign m_axi.arvalid       = arvalid_q;
  assign m_axi.rready        = rready_q;
  assign m_axi.awaddr        = awaddr_q;
  assign m_axi.awvalid       = awvalid_q;
  assign m_axi.wdata         = wdata_q;
  assign m_axi.wvalid        = wvalid_q;
  assign m_axi.bready        = bready_q;
  assign enabled_tasks       = enabled_q;
  assign task_fail           = task_fail_q;
  assign current_task_number = cur_q;
  assign busy                = busy_q;
  assign bus_error           = bus_error_q;
  assign tasks_done          = done_q;
endmodule

// File: tb/tb_task_sequencer_axil.sv
// Randomised bench: a scripted peripheral answers the sequencer while a scenario model predicts
// the bus transactions and final task results; literal cases pin the model to known answers.
module tb_task_sequencer_axil;
  localparam int          NT    = 8;
  localparam int          PL    = 4;
  localparam logic [31:0] BASE  = 32'h4000_0000;
  localparam logic [31:0] A_EN  = BASE;
  localparam logic [31:0] A_CMD = BASE + 32'h4;
  localparam logic [31:0] A_ST  = BASE + 32'h8;

  typedef struct {
    int          kind;   // 0 = read at val, 1 = CMD write of task val
    logic [31:0] val;
  } ev_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_tests;
  logic [NT-1:0] enabled_tasks, task_fail;
  logic [31:0]   current_task_number;
  logic          busy, bus_error, tasks_done;

  task_sequencer_axil_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  task_sequencer_axil #(
    .M_AXI_ADDR_WIDTH(32), .M_AXI_DATA_WIDTH(32), .NUM_TASKS(NT),
    .BASE_ADDR(BASE), .POLL_LIMIT(PL)
  ) dut (
    .i_clk(clk), .i_rst(rst), .m_axi(bus),
    .start_tests(start_tests), .enabled_tasks(enabled_tasks),
    .current_task_number(current_task_number), .busy(busy),
    .task_fail(task_fail), .bus_error(bus_error), .tasks_done(tasks_done)
  );

  always #5 clk = ~clk;

  int vec = 0, errs = 0;

  // Scenario seen by the peripheral
  logic [31:0] en_reg;
  int          polls[NT];
  bit          fbit[NT];
  bit          berr[NT];
  int          rerr[NT];
  bit          hold_r;
  int          rdy_pct = 50;

  // Model predictions
  ev_t           exp_q[$];
  logic [NT-1:0] exp_fail;
  bit            exp_berr, exp_empty;
  bit            restart_pending, expect_restart;

  // Observations
  int done_cnt = 0, w_cnt, st_reads, en_reads, last_lat;
  int w_log[$];
  int cyc = 0, en_fire_cyc = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic flag(input string nm, input logic [63:0] act);
    vec++;
    errs++;
    $display("FAIL %s: observed 0x%0h", nm, act);
  endtask

  // Expected transactions and results straight from the sequencing rules.
  task automatic build_model();
    bit stop;
    stop      = 1'b0;
    exp_fail  = '0;
    exp_berr  = 1'b0;
    exp_empty = 1'b1;
    exp_q.push_back('{0, A_EN});
    for (int t = 0; t < NT && !stop; t++) begin
      if (en_reg[t]) begin
        int reads;
        exp_empty = 1'b0;
        exp_q.push_back('{1, 32'(t)});
        if (berr[t]) begin
          exp_berr = 1'b1;
          stop     = 1'b1;
        end else begin
          reads = (polls[t] < PL) ? polls[t] : PL;
          for (int k = 1; k <= reads && !stop; k++) begin
            exp_q.push_back('{0, A_ST});
            if (rerr[t] == k) begin
              exp_berr = 1'b1;
              stop     = 1'b1;
            end
          end
          if (!stop) exp_fail[t] = (polls[t] <= PL) ? fbit[t] : 1'b1;
        end
      end
    end
  endtask

  // Peripheral + per-cycle compare process
  initial begin : mon
    bit          r_pend, b_pend, aw_got, w_got, r_fire, b_fire, r_is_en;
    int          r_dly, b_dly, cur_t, st_cnt;
    logic [31:0] r_dat, w_dat;
    logic [1:0]  r_rsp, b_rsp;
    bit          p_arv, p_ar_f, p_awv, p_aw_f, p_wv, p_w_f, p_done;
    logic [31:0] p_ara, p_awa, p_wd;
    ev_t         ev;
    {r_pend, b_pend, aw_got, w_got, r_fire, b_fire, r_is_en} = '0;
    {p_arv, p_ar_f, p_awv, p_aw_f, p_wv, p_w_f, p_done} = '0;
    r_dly = 0; b_dly = 0; cur_t = 0; st_cnt = 0;
    r_dat = '0; w_dat = '0; r_rsp = '0; b_rsp = '0;
    p_ara = '0; p_awa = '0; p_wd = '0;
    bus.awready = 1'b0; bus.wready = 1'b0; bus.arready = 1'b0;
    bus.rvalid = 1'b0; bus.rdata = '0; bus.rresp = '0;
    bus.bvalid = 1'b0; bus.bresp = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        bus.awready = 1'b0; bus.wready = 1'b0; bus.arready = 1'b0;
        bus.rvalid = 1'b0; bus.bvalid = 1'b0;
        {r_pend, b_pend, aw_got, w_got, r_fire, b_fire} = '0;
        {p_arv, p_ar_f, p_awv, p_aw_f, p_wv, p_w_f, p_done} = '0;
        expect_restart = 1'b0;
        continue;
      end
      if (r_fire) begin bus.rvalid = 1'b0; r_fire = 1'b0; end
      if (b_fire) begin bus.bvalid = 1'b0; b_fire = 1'b0; end

      // Valid/payload stability, and drop after handshake
      if (p_ar_f) chk("ar_drop", bus.arvalid, 0);
      else if (p_arv) chk("ar_hold", {bus.arvalid, bus.araddr}, {1'b1, p_ara});
      if (p_aw_f) chk("aw_drop", bus.awvalid, 0);
      else if (p_awv) chk("aw_hold", {bus.awvalid, bus.awaddr}, {1'b1, p_awa});
      if (p_w_f) chk("w_drop", bus.wvalid, 0);
      else if (p_wv) chk("w_hold", {bus.wvalid, bus.wdata}, {1'b1, p_wd});

      if (expect_restart) begin
        chk("restart_arvalid", bus.arvalid, 1);
        expect_restart = 1'b0;
      end

      if (tasks_done) begin
        done_cnt++;
        chk("done_single", p_done, 0);
        chk("busy_at_done", busy, 0);
        chk("task_fail", task_fail, exp_fail);
        chk("bus_error", bus_error, exp_berr);
        chk("enabled_tasks", enabled_tasks, en_reg[NT-1:0]);
        chk("txn_left", exp_q.size(), 0);
        last_lat = cyc - en_fire_cyc;
        if (exp_empty && !exp_berr) chk("empty_latency", last_lat, 3);
        if (restart_pending) begin
          build_model();
          restart_pending = 1'b0;
          expect_restart  = 1'b1;
        end
      end

      bus.awready = ($urandom_range(0, 99) < rdy_pct);
      bus.wready  = ($urandom_range(0, 99) < rdy_pct);
      bus.arready = ($urandom_range(0, 99) < rdy_pct);
      if (r_pend && !bus.rvalid) begin
        if (r_dly == 0) begin
          bus.rvalid = 1'b1; bus.rdata = r_dat; bus.rresp = r_rsp; r_pend = 1'b0;
        end else r_dly--;
      end
      if (b_pend && !bus.bvalid) begin
        if (b_dly == 0) begin
          bus.bvalid = 1'b1; bus.bresp = b_rsp; b_pend = 1'b0;
        end else b_dly--;
      end

      // Handshakes that complete at the coming edge
      p_arv = bus.arvalid; p_ara = bus.araddr; p_ar_f = bus.arvalid && bus.arready;
      p_awv = bus.awvalid; p_awa = bus.awaddr; p_aw_f = bus.awvalid && bus.awready;
      p_wv  = bus.wvalid;  p_wd  = bus.wdata;  p_w_f  = bus.wvalid && bus.wready;
      p_done = tasks_done;

      if (p_ar_f) begin
        chk("busy_ar", busy, 1);
        chk("ar_outstanding", {r_pend, bus.rvalid, b_pend, bus.bvalid, aw_got, w_got}, 0);
        if (exp_q.size() == 0) flag("ar_unexpected", bus.araddr);
        else begin
          ev = exp_q.pop_front();
          chk("ar_kind", ev.kind, 0);
          chk("ar_addr", bus.araddr, ev.val);
        end
        r_is_en = (bus.araddr == A_EN);
        if (r_is_en) begin
          en_reads++;
          r_dat = en_reg;
          r_rsp = 2'b00;
          r_dly = $urandom_range(0, 3);
        end else begin
          st_reads++;
          st_cnt++;
          chk("cur_task_st", current_task_number, cur_t);
          r_rsp = (st_cnt == rerr[cur_t]) ? 2'b10 : 2'b00;
          if (st_cnt >= polls[cur_t])
            r_dat = ($urandom() & 32'hFFFF_FFFC) | {30'd0, fbit[cur_t], 1'b1};
          else
            r_dat = $urandom() & 32'hFFFF_FFFE;
          r_dly = hold_r ? 1000000 : $urandom_range(0, 3);
        end
        r_pend = 1'b1;
      end

      if (p_aw_f) begin
        aw_got = 1'b1;
        chk("awaddr", bus.awaddr, A_CMD);
      end
      if (p_w_f) begin
        w_got = 1'b1;
        w_dat = bus.wdata;
      end
      if (aw_got && w_got) begin
        aw_got = 1'b0; w_got = 1'b0;
        chk("busy_w", busy, 1);
        chk("w_outstanding", {r_pend, bus.rvalid}, 0);
        if (exp_q.size() == 0) flag("w_unexpected", w_dat);
        else begin
          ev = exp_q.pop_front();
          chk("w_kind", ev.kind, 1);
          chk("w_data", w_dat, ev.val);
        end
        chk("cur_task_w", current_task_number, w_dat);
        w_cnt++;
        w_log.push_back(int'(w_dat));
        cur_t  = int'(w_dat[2:0]);
        st_cnt = 0;
        b_rsp  = berr[cur_t] ? 2'b10 : 2'b00;
        b_dly  = $urandom_range(0, 3);
        b_pend = 1'b1;
      end

      r_fire = bus.rvalid && bus.rready;
      if (r_fire && r_is_en) en_fire_cyc = cyc;
      b_fire = bus.bvalid && bus.bready;
    end
  end

  task automatic clear_scn();
    for (int t = 0; t < NT; t++) begin
      polls[t] = 1; fbit[t] = 1'b0; berr[t] = 1'b0; rerr[t] = 0;
    end
    hold_r = 1'b0;
  endtask

  task automatic run_seq(input bit hold);
    int  target, n;
    bit  dropped;
    exp_q.delete();
    w_log.delete();
    w_cnt = 0; st_reads = 0; en_reads = 0;
    build_model();
    restart_pending = hold;
    target  = done_cnt + (hold ? 2 : 1);
    dropped = 1'b0;
    start_tests = 1'b1;
    @(negedge clk);
    if (!hold) start_tests = 1'b0;
    n = 0;
    while (done_cnt < target && n < 3000) begin
      @(negedge clk);
      n++;
      if (hold && !dropped && done_cnt >= target - 1) begin
        @(negedge clk);
        start_tests = 1'b0;
        dropped = 1'b1;
      end
    end
    start_tests = 1'b0;
    if (done_cnt < target) flag("done_timeout", done_cnt);
    repeat (4) @(negedge clk);
    chk("done_count", done_cnt, target);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ctrl"}, {busy, tasks_done, bus_error, task_fail, enabled_tasks}, 0);
    chk({tag, "_cur"}, current_task_number, 0);
    chk({tag, "_valids"}, {bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.bready}, 0);
    chk({tag, "_payload"}, {bus.araddr, bus.awaddr}, 0);
    chk({tag, "_wdata"}, bus.wdata, 0);
  endtask

  initial begin : main
    int n;
    rst = 1'b1;
    start_tests = 1'b0;
    clear_scn();
    en_reg = '0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Two tasks, immediate completion
    clear_scn(); en_reg = 32'h0000_0005;
    run_seq(1'b0);
    chk("c1_writes", w_cnt, 2);
    chk("c1_w0", w_log[0], 0);
    chk("c1_w1", w_log[1], 2);
    chk("c1_fail", task_fail, 0);
    chk("c1_berr", bus_error, 0);

    // Empty mask
    clear_scn(); en_reg = 32'h0;
    run_seq(1'b0);
    chk("c2_reads", en_reads + st_reads, 1);
    chk("c2_writes", w_cnt, 0);
    chk("c2_latency", last_lat, 3);

    // Poll timeout
    clear_scn(); en_reg = 32'h1; polls[0] = 100;
    run_seq(1'b0);
    chk("c3_model_fail", exp_fail, 8'h01);
    chk("c3_status_reads", st_reads, 4);
    chk("c3_fail", task_fail, 8'h01);

    // Fail bit then write-response error
    clear_scn(); en_reg = 32'h3; fbit[0] = 1'b1; berr[1] = 1'b1;
    run_seq(1'b0);
    chk("c4_model_berr", exp_berr, 1);
    chk("c4_fail", task_fail, 8'h01);
    chk("c4_berr", bus_error, 1);
    chk("c4_status_reads", st_reads, 1);

    // Only the top index, with junk above the mask
    clear_scn(); en_reg = 32'hFFFF_FF80; polls[7] = 2; fbit[7] = 1'b1;
    run_seq(1'b0);
    chk("top_writes", w_cnt, 1);
    chk("top_w0", w_log[0], 7);
    chk("top_fail", task_fail, 8'h80);

    // start held high across DONE
    clear_scn(); en_reg = 32'h0000_0012; polls[4] = 3;
    run_seq(1'b1);

    // Random scenarios and stalls
    for (int r = 0; r < 40; r++) begin
      rdy_pct = $urandom_range(20, 100);
      clear_scn();
      case ($urandom_range(0, 4))
        0:       en_reg = $urandom() & 32'hFFFF_FF00;
        1:       en_reg = $urandom() | 32'h0000_0081;
        default: en_reg = $urandom();
      endcase
      for (int t = 0; t < NT; t++) begin
        polls[t] = $urandom_range(1, 6);
        fbit[t]  = 1'($urandom_range(0, 1));
        berr[t]  = ($urandom_range(0, 19) == 0);
        rerr[t]  = ($urandom_range(0, 19) == 0) ? $urandom_range(1, 4) : 0;
      end
      run_seq(1'b0);
    end

    // Reset while waiting on a STATUS beat
    rdy_pct = 60;
    clear_scn(); en_reg = 32'h4; hold_r = 1'b1;
    exp_q.delete();
    build_model();
    st_reads = 0;
    start_tests = 1'b1;
    @(negedge clk);
    start_tests = 1'b0;
    n = 0;
    while (!(st_reads > 0 && bus.rready) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) flag("st_r_timeout", st_reads);
    rst = 1'b1;
    #1;
    check_zero("midrst");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    clear_scn(); en_reg = 32'h6; polls[2] = 2; fbit[1] = 1'b1;
    run_seq(1'b0);
    chk("c6_writes", w_cnt, 2);
    chk("c6_fail", task_fail, 8'h02);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
